// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline: load-use bubbles, E2 branch flush, memory freeze.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
   parameter int LOAD_LAT    = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  ResultSrcE1,
   input  logic [4:0]  RD_E1,
   input  logic [1:0]  ResultSrcE2,
   input  logic [4:0]  RD_E2,
   input  logic [4:0]  Rs1_D,
   input  logic [4:0]  Rs2_D,
   input  logic        PCSrcE2,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE1,
   output logic        mem_timeout,
   output logic [1:0]  ctrl_state
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_mem_wait
`endif
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LD1  = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LD2  = CNT_W'(LOAD_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_TOUT = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   state_t           saved_state_q, saved_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] saved_cnt_q, saved_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;

   logic             ld_e1, ld_e2, memwait, timeout_hit;
   state_t           eff_state;
   logic [CNT_W-1:0] eff_cnt;
   logic             stall_fd, stall_em, flush_d, flush_e1;

   assign ld_e1 = (ResultSrcE1 == 2'b01) && (RD_E1 != 5'd0) &&
                  ((RD_E1 == Rs1_D) || (RD_E1 == Rs2_D));
   assign ld_e2 = (ResultSrcE2 == 2'b01) && (RD_E2 != 5'd0) &&
                  ((RD_E2 == Rs1_D) || (RD_E2 == Rs2_D));
   assign memwait     = mem_req && !mem_ready;
   assign timeout_hit = (state_q == ST_MEMWAIT) && (cnt_q == CNT_TOUT);

   // On the cycle a memory wait ends, act as the suspended state would.
   assign eff_state = (state_q == ST_MEMWAIT) ? saved_state_q : state_q;
   assign eff_cnt   = (state_q == ST_MEMWAIT) ? saved_cnt_q   : cnt_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      saved_state_d = saved_state_q;
      saved_cnt_d   = saved_cnt_q;
      mem_timeout_d = mem_timeout_q;
      stall_fd      = 1'b0;
      stall_em      = 1'b0;
      flush_d       = 1'b0;
      flush_e1      = 1'b0;

      if (memwait && !timeout_hit) begin
         stall_fd = 1'b1;
         stall_em = 1'b1;
         if (state_q != ST_MEMWAIT) begin
            saved_state_d = state_q;
            saved_cnt_d   = cnt_q;
            state_d       = ST_MEMWAIT;
            cnt_d         = CNT_ONE;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         if (timeout_hit) begin
            mem_timeout_d = 1'b1;
         end
         if (PCSrcE2) begin
            flush_d  = 1'b1;
            flush_e1 = 1'b1;
            state_d  = ST_RUN;
            cnt_d    = '0;
         end else if (eff_state == ST_LDSTALL) begin
            stall_fd = 1'b1;
            flush_e1 = 1'b1;
            if (eff_cnt == CNT_ONE) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               state_d = ST_LDSTALL;
               cnt_d   = eff_cnt - CNT_ONE;
            end
         end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
            if (ld_e1) begin
               stall_fd = 1'b1;
               flush_e1 = 1'b1;
               if (LOAD_LAT - 1 > 0) begin
                  state_d = ST_LDSTALL;
                  cnt_d   = CNT_LD1;
               end
            end else if (ld_e2) begin
               stall_fd = 1'b1;
               flush_e1 = 1'b1;
               if (LOAD_LAT - 2 > 0) begin
                  state_d = ST_LDSTALL;
                  cnt_d   = CNT_LD2;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         saved_state_q <= ST_RUN;
         saved_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         saved_state_q <= saved_state_d;
         saved_cnt_q   <= saved_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Enables are forced low while reset is held, independent of the hazard inputs.
   assign StallF      = stall_fd & ~rst;
   assign StallD      = stall_fd & ~rst;
   assign StallE      = stall_em & ~rst;
   assign StallM      = stall_em & ~rst;
   assign FlushD      = flush_d  & ~rst;
   assign FlushE1     = flush_e1 & ~rst;
   assign mem_timeout = mem_timeout_q;
   assign ctrl_state  = state_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;
   logic [31:0] perf_mem_q,   perf_mem_d;

   always_comb begin
      perf_stall_d = perf_stall_q + {31'd0, StallF};
      perf_flush_d = perf_flush_q + {31'd0, FlushD};
      perf_mem_d   = perf_mem_q   + {31'd0, memwait};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         perf_mem_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
         perf_mem_q   <= perf_mem_d;
      end
   end

   assign perf_stall_cyc = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
   assign perf_mem_wait  = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (LOAD_LAT=2, MEM_TIMEOUT=4).
// Expected vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE1,mem_timeout,ctrl_state}.
module tb_pipeline_stall_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  ResultSrcE1;
   logic [4:0]  RD_E1;
   logic [1:0]  ResultSrcE2;
   logic [4:0]  RD_E2;
   logic [4:0]  Rs1_D;
   logic [4:0]  Rs2_D;
   logic        PCSrcE2;
   logic        mem_req;
   logic        mem_ready;
   logic        StallF, StallD, StallE, StallM;
   logic        FlushD, FlushE1;
   logic        mem_timeout;
   logic [1:0]  ctrl_state;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   pipeline_stall_ctrl #(
      .LOAD_LAT    (2),
      .MEM_TIMEOUT (4),
      .CNT_W       (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ResultSrcE1 (ResultSrcE1),
      .RD_E1       (RD_E1),
      .ResultSrcE2 (ResultSrcE2),
      .RD_E2       (RD_E2),
      .Rs1_D       (Rs1_D),
      .Rs2_D       (Rs2_D),
      .PCSrcE2     (PCSrcE2),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE1     (FlushE1),
      .mem_timeout (mem_timeout),
      .ctrl_state  (ctrl_state)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one popped expectation against what the DUT is presenting.
   function automatic void checkOutput(input exp_t e);
      logic [8:0] act;
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE1, mem_timeout, ctrl_state};
      checks++;
      if (act !== e.exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b, expected %b", e.name, act, e.exp);
      end
   endfunction

   // Monitor: pops at the falling edge whatever the stimulus side queued for this cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         checkOutput(q.pop_front());
      end
   end

   // Drives one cycle of inputs just after the rising edge and queues the expected response.
   task automatic applyStimulus(
      input string      name,
      input logic [1:0] rs_e1, input logic [4:0] rd_e1,
      input logic [1:0] rs_e2, input logic [4:0] rd_e2,
      input logic [4:0] s1,    input logic [4:0] s2,
      input logic       pc,    input logic mreq, input logic mrdy, input logic rstv,
      input logic [3:0] exp_stall, input logic [1:0] exp_flush,
      input logic       exp_to,    input logic [1:0] exp_st);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = rstv;
      ResultSrcE1 = rs_e1;
      RD_E1       = rd_e1;
      ResultSrcE2 = rs_e2;
      RD_E2       = rd_e2;
      Rs1_D       = s1;
      Rs2_D       = s2;
      PCSrcE2     = pc;
      mem_req     = mreq;
      mem_ready   = mrdy;
      e.name = name;
      e.exp  = {exp_stall, exp_flush, exp_to, exp_st};
      q.push_back(e);
   endtask

   task automatic idle(input string name, input logic exp_to);
      applyStimulus(name, 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b0000, 2'b00, exp_to, 2'd0);
   endtask

   // Directed sequence; stall nibble is {F,D,E,M}, flush pair is {FlushD,FlushE1}.
   initial begin
      rst = 1'b1;
      ResultSrcE1 = 2'b00; RD_E1 = 5'd0; ResultSrcE2 = 2'b00; RD_E2 = 5'd0;
      Rs1_D = 5'd0; Rs2_D = 5'd0; PCSrcE2 = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

      // Reset held with a hazard and a memory wait present: everything stays low.
      applyStimulus("reset_hold", 2'b01, 5'd5, 2'b00, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1,
                    4'b0000, 2'b00, 1'b0, 2'd0);
      idle("reset_release", 1'b0);

      // Load in E1 feeding D: two bubble cycles, then RUN.
      applyStimulus("lduse_e1_c1", 2'b01, 5'd5, 2'b00, 5'd0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      applyStimulus("lduse_e1_c2", 2'b01, 5'd5, 2'b00, 5'd0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd1);
      idle("lduse_e1_done", 1'b0);

      // Load to x0 never stalls.
      applyStimulus("load_x0", 2'b01, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b0000, 2'b00, 1'b0, 2'd0);
      idle("load_x0_after", 1'b0);

      // Load in E2 needs LOAD_LAT-1 = 1 bubble, no LDSTALL entry.
      applyStimulus("lduse_e2", 2'b00, 5'd0, 2'b01, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      idle("lduse_e2_after", 1'b0);

      // Branch on the second stall cycle cancels LDSTALL.
      applyStimulus("br_ld_c1", 2'b01, 5'd3, 2'b00, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      applyStimulus("br_ld_c2", 2'b01, 5'd3, 2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                    4'b0000, 2'b11, 1'b0, 2'd1);
      idle("br_ld_after", 1'b0);

      // Back-to-back load-use sequences with no gap.
      applyStimulus("b2b_a1", 2'b01, 5'd9, 2'b00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      applyStimulus("b2b_a2", 2'b01, 5'd9, 2'b00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd1);
      applyStimulus("b2b_b1", 2'b01, 5'd10, 2'b00, 5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      applyStimulus("b2b_b2", 2'b01, 5'd10, 2'b00, 5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd1);
      idle("b2b_done", 1'b0);

      // Memory wait of 3 cycles, released by mem_ready.
      applyStimulus("mw_c1", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    4'b1111, 2'b00, 1'b0, 2'd0);
      applyStimulus("mw_c2", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    4'b1111, 2'b00, 1'b0, 2'd2);
      applyStimulus("mw_c3", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    4'b1111, 2'b00, 1'b0, 2'd2);
      applyStimulus("mw_ready", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                    4'b0000, 2'b00, 1'b0, 2'd2);
      idle("mw_after", 1'b0);

      // Memory wait interrupting LDSTALL resumes the saved bubble afterwards.
      applyStimulus("mwld_c1", 2'b01, 5'd4, 2'b00, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd0);
      applyStimulus("mwld_c2", 2'b01, 5'd4, 2'b00, 5'd0, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                    4'b1111, 2'b00, 1'b0, 2'd1);
      applyStimulus("mwld_ready", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                    4'b1100, 2'b01, 1'b0, 2'd2);
      idle("mwld_after", 1'b0);

      // Timeout: four stall cycles, one released cycle, sticky flag afterwards.
      applyStimulus("to_c1", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    4'b1111, 2'b00, 1'b0, 2'd0);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus($sformatf("to_c%0d", i), 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0,
                       1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 1'b0, 2'd2);
      end
      applyStimulus("to_release", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    4'b0000, 2'b00, 1'b0, 2'd2);
      idle("to_sticky1", 1'b1);
      idle("to_sticky2", 1'b1);

      // Plain taken branch.
      applyStimulus("branch", 2'b00, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                    4'b0000, 2'b11, 1'b1, 2'd0);

      // Asynchronous reset in the middle of LDSTALL.
      applyStimulus("rst_ld_c1", 2'b01, 5'd6, 2'b00, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    4'b1100, 2'b01, 1'b1, 2'd0);
      applyStimulus("rst_mid", 2'b01, 5'd6, 2'b00, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                    4'b0000, 2'b00, 1'b0, 2'd0);
      applyStimulus("rst_held", 2'b01, 5'd6, 2'b00, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                    4'b0000, 2'b00, 1'b0, 2'd0);
      idle("rst_after1", 1'b0);
      idle("rst_after2", 1'b0);

      // Let the monitor drain, with a bounded wait.
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 6-stage pipeline (F, D, E1, E2, M, W).
- Detects load-use hazards that W-stage forwarding cannot cover and inserts bubbles.
- Flushes wrong-path instructions on a taken branch or jump resolved in E2.
- Freezes the pipeline while data memory handshakes.
- Sits beside hazard_unit_6stage, which keeps doing the forwarding selects; this block drives the stall and flush enables of the stage registers.

Parameters:
LOAD_LAT, 2, bubble cycles required when a load in E1 feeds the instruction in D; a load in E2 needs LOAD_LAT-1.
MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before forced release.
CNT_W, 5, width of the internal cycle counter; must hold max(LOAD_LAT, MEM_TIMEOUT).

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
ResultSrcE1  in  2  result select of instruction in E1; 2'b01 = load
RD_E1  in  5  destination register in E1
ResultSrcE2  in  2  result select in E2
RD_E2  in  5  destination register in E2
Rs1_D  in  5  source 1 of instruction in D
Rs2_D  in  5  source 2 of instruction in D
PCSrcE2  in  1  taken branch/jump resolved in E2
mem_req  in  1  M-stage access to data memory this cycle
mem_ready  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E1 and E1/E2 registers
StallM  out  1  hold E2/M and M/W registers
FlushD  out  1  clear F/D register (bubble)
FlushE1  out  1  clear D/E1 register (bubble)
mem_timeout  out  1  sticky: a memory wait hit MEM_TIMEOUT
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Reset (rst high, asynchronous): state=RUN, cnt=0, mem_timeout=0. While rst is high, every stall and flush output is 0.
- States: RUN=0, LDSTALL=1, MEMWAIT=2.
- Outputs are combinational from state and current inputs, so they take effect in the same cycle. All state updates happen on the clk rising edge.
- Hazard terms:
  - ldE1 = ResultSrcE1==2'b01 && RD_E1!=0 && (RD_E1==Rs1_D || RD_E1==Rs2_D).
  - ldE2 is the same test using E2 signals.
  - memwait = mem_req && !mem_ready.
- Priority, highest first: memwait, PCSrcE2, load-use.
- memwait (any state):
  - StallF=StallD=StallE=StallM=1; no flushes.
  - Entering from RUN or LDSTALL: go to MEMWAIT and load cnt=1. The state and cnt of a suspended LDSTALL are saved and restored on exit.
  - In MEMWAIT, cnt increments each cycle. When mem_ready=1, stalls drop in that same cycle and the FSM returns to the saved state.
  - If cnt reaches MEM_TIMEOUT: set mem_timeout=1, drop stalls for one cycle, and return to the saved state. The memory stage treats that access as complete. mem_timeout clears only on reset.
- PCSrcE2=1 with no memwait:
  - FlushD=1 and FlushE1=1 for exactly that cycle; stalls are 0.
  - The FSM goes to RUN and cnt=0, cancelling any LDSTALL, because the dependent instruction is flushed.
  - The fixed branch penalty is 2 bubbles.
- Load-use in RUN:
  - ldE1: StallF=StallD=1 and FlushE1=1 in the current cycle. If LOAD_LAT-1>0, go to LDSTALL with cnt=LOAD_LAT-1.
  - Otherwise ldE2: same outputs for one cycle; if LOAD_LAT-2>0, go to LDSTALL with cnt=LOAD_LAT-2.
  - ldE1 has precedence when both are true.
- LDSTALL: StallF=StallD=1 and FlushE1=1. cnt decrements each cycle; go to RUN when cnt==1 at the clock edge. Hazard inputs are not re-evaluated inside LDSTALL.
- Back-to-back loads: a new hazard detected on the first RUN cycle after LDSTALL restarts the sequence. There are no dead cycles between sequences.
- StallE and StallM are asserted only for memwait.

Optional Feature:
PIPE_PERF_CNT_EN.
- When defined, add outputs perf_stall_cyc[31:0], perf_flush_cnt[31:0], perf_mem_wait[31:0], each reset to 0.
  - perf_stall_cyc increments on every cycle with StallF=1.
  - perf_flush_cnt increments on every cycle with a PCSrcE2 flush.
  - perf_mem_wait increments on every memwait cycle.
  - Counters wrap at 2^32.
- When undefined, these ports and registers do not exist and the block's behaviour is otherwise identical.

Test Plan:
- Load-use, E1 match: E1 lw x5 (ResultSrcE1=01, RD_E1=5), D add uses Rs1_D=5 -> StallF/StallD/FlushE1 high for exactly 2 cycles, then RUN.
- Load to x0: RD_E1=0 with Rs1_D=0 -> no stall, no flush; ctrl_state stays 0.
- Branch during LDSTALL: assert PCSrcE2 on the 2nd stall cycle -> FlushD=FlushE1=1 for that cycle, stalls 0, next cycle ctrl_state=0.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles then 1 -> all four stalls high for 3 cycles, low on the ready cycle; mem_timeout stays 0.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 -> stalls high for 4 cycles; mem_timeout=1 and stays set; stalls drop for one cycle.
- Reset mid-sequence: assert rst asynchronously during LDSTALL -> all outputs 0 immediately; after release, ctrl_state=0 and no residual stall.
